opr_stage: RTL and testbench

- Single-lane operand-supply pipeline stage that produces the s1/s2/opc bundle consumed by the ALU in the execute unit.
- Accepts a decoded instruction through a valid/ready handshake and resolves operands: register file, two-lane result bypass, immediate or PC.
- Holds the resolved bundle in a registered output with valid/ready backpressure. One instance per issue lane.

---
 rtl/srv_defs_pkg.sv | 42 ++++
 rtl/opr_stage_fwd_mux.sv | 52 +++++
 rtl/opr_stage.sv | 214 +++++++++++++++++++++
 tb/tb_opr_stage.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/srv_defs_pkg.sv
// -----------------------------------------------------------------------------
// srv_defs : shared definitions for the operand-supply stage.
//
// Contents
//   XLEN, REG_IDX_W  : default operand and register-index widths
//   alu_opcode_t     : ALU operation encoding consumed by the execute unit
//   opr_bundle_t     : operand bundle handed to the ALU {s1, s2, opc, rd}
//   OPR_BUNDLE_RESET : value of a bundle register out of reset
// -----------------------------------------------------------------------------
package srv_defs;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_opcode_t;

    typedef struct packed {
        logic [XLEN-1:0]      s1;
        logic [XLEN-1:0]      s2;
        alu_opcode_t          opc;
        logic [REG_IDX_W-1:0] rd;
    } opr_bundle_t;

    localparam opr_bundle_t OPR_BUNDLE_RESET = '{
        s1:  '0,
        s2:  '0,
        opc: ALU_ADD,
        rd:  '0
    };

endpackage

// File: rtl/opr_stage_fwd_mux.sv
// -----------------------------------------------------------------------------
// opr_fwd_mux : combinational source selection for one operand.
//
// Priority, highest first:
//   1. register index 0 reads as zero, whatever the bypass carries
//   2. bypass lane 1 (younger result) with a matching destination
//   3. bypass lane 0 with a matching destination
//   4. register file read data
// A bypass lane whose destination is register 0 never matches.
//
// Ports
//   src_idx   in  source register index
//   rf_rdata  in  register file read data for src_idx
//   byp_valid in  per-lane bypass valid
//   byp_rd    in  per-lane bypass destination index
//   byp_data  in  per-lane bypass result
//   src_data  out resolved operand value
// -----------------------------------------------------------------------------
module opr_fwd_mux #(
    parameter int XLEN      = 32,
    parameter int REG_IDX_W = 5
) (
    input  logic [REG_IDX_W-1:0]      src_idx,
    input  logic [XLEN-1:0]           rf_rdata,
    input  logic [1:0]                byp_valid,
    input  logic [1:0][REG_IDX_W-1:0] byp_rd,
    input  logic [1:0][XLEN-1:0]      byp_data,
    output logic [XLEN-1:0]           src_data
);

    logic       src_is_zero;
    logic [1:0] byp_hit;

    always_comb begin
        src_is_zero = (src_idx == '0);
        // The rd != 0 term keeps a lane writing x0 from ever forwarding.
        byp_hit[0]  = byp_valid[0] && (byp_rd[0] == src_idx) && (byp_rd[0] != '0);
        byp_hit[1]  = byp_valid[1] && (byp_rd[1] == src_idx) && (byp_rd[1] != '0);
    end

    always_comb begin
        src_data = rf_rdata;
        if (src_is_zero) begin
            src_data = '0;
        end else if (byp_hit[1]) begin
            src_data = byp_data[1];
        end else if (byp_hit[0]) begin
            src_data = byp_data[0];
        end
    end

endmodule

// File: rtl/opr_stage.sv
// -----------------------------------------------------------------------------
// opr_stage : single-lane operand-supply stage feeding the ALU.
//
// A decoded instruction is accepted on in_valid & in_ready. At that edge both
// operands are resolved (x0 / bypass lane 1 / bypass lane 0 / register file),
// optionally replaced by PC (s1) or immediate (s2), and registered together
// with opc and rd. The registered bundle is offered on out_valid / out_ready
// and never changes while held.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never drops and the payload never changes until the
// transfer, except through flush or reset, which discard held bundles.
//
// Build option SRV_OPR_SKID_EN
//   undefined : one output register, in_ready = ~out_valid | out_ready
//               (combinational from out_ready)
//   defined   : an extra one-entry skid register catches an instruction
//               accepted while the output is stalled; in_ready = ~skid_valid,
//               a pure register output. Ordering is preserved.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   flush                    drop held bundles and any instruction accepted
//                            in the same cycle
//   in_valid / in_ready      upstream handshake
//   in_rs1, in_rs2, in_rd    source and destination indices
//   in_pc, in_imm            instruction address and sign-extended immediate
//   in_use_pc, in_use_imm    select pc for s1 / immediate for s2
//   in_opc                   ALU operation
//   rf_rdata1, rf_rdata2     register file read data for in_rs1 / in_rs2
//   byp_valid/byp_rd/byp_data two-lane result bypass (lane 1 younger)
//   out_valid / out_ready    downstream handshake
//   out_s1, out_s2, out_opc, out_rd  registered ALU bundle
//
// XLEN and REG_IDX_W must match the widths in srv_defs, since the bundle
// registers use the shared opr_bundle_t layout.
// -----------------------------------------------------------------------------
module opr_stage
    import srv_defs::alu_opcode_t;
    import srv_defs::opr_bundle_t;
#(
    parameter int XLEN      = srv_defs::XLEN,
    parameter int REG_IDX_W = srv_defs::REG_IDX_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,

    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [REG_IDX_W-1:0]      in_rs1,
    input  logic [REG_IDX_W-1:0]      in_rs2,
    input  logic [REG_IDX_W-1:0]      in_rd,
    input  logic [XLEN-1:0]           in_pc,
    input  logic [XLEN-1:0]           in_imm,
    input  logic                      in_use_pc,
    input  logic                      in_use_imm,
    input  alu_opcode_t               in_opc,

    input  logic [XLEN-1:0]           rf_rdata1,
    input  logic [XLEN-1:0]           rf_rdata2,

    input  logic [1:0]                byp_valid,
    input  logic [1:0][REG_IDX_W-1:0] byp_rd,
    input  logic [1:0][XLEN-1:0]      byp_data,

    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_s1,
    output logic [XLEN-1:0]           out_s2,
    output alu_opcode_t               out_opc,
    output logic [REG_IDX_W-1:0]      out_rd
);

    // -------------------------------------------------------------------------
    // Operand resolution (combinational, sampled only at the accept edge)
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    opr_bundle_t     res_bundle;
    logic            accept;

    opr_fwd_mux #(
        .XLEN      (XLEN),
        .REG_IDX_W (REG_IDX_W)
    ) u_fwd_s1 (
        .src_idx   (in_rs1),
        .rf_rdata  (rf_rdata1),
        .byp_valid (byp_valid),
        .byp_rd    (byp_rd),
        .byp_data  (byp_data),
        .src_data  (src1)
    );

    opr_fwd_mux #(
        .XLEN      (XLEN),
        .REG_IDX_W (REG_IDX_W)
    ) u_fwd_s2 (
        .src_idx   (in_rs2),
        .rf_rdata  (rf_rdata2),
        .byp_valid (byp_valid),
        .byp_rd    (byp_rd),
        .byp_data  (byp_data),
        .src_data  (src2)
    );

    always_comb begin
        res_bundle     = srv_defs::OPR_BUNDLE_RESET;
        res_bundle.s1  = in_use_pc  ? in_pc  : src1;
        res_bundle.s2  = in_use_imm ? in_imm : src2;
        res_bundle.opc = in_opc;
        res_bundle.rd  = in_rd;
    end

    assign accept = in_valid && in_ready;

    // -------------------------------------------------------------------------
    // Output register (and skid register when enabled)
    // -------------------------------------------------------------------------
    logic        out_valid_q;
    logic        out_valid_d;
    opr_bundle_t out_bundle_q;
    opr_bundle_t out_bundle_d;

`ifdef SRV_OPR_SKID_EN

    logic        skid_valid_q;
    logic        skid_valid_d;
    opr_bundle_t skid_bundle_q;
    opr_bundle_t skid_bundle_d;

    // Ready depends only on skid occupancy, so it is a flop output.
    assign in_ready = !skid_valid_q;

    always_comb begin
        out_valid_d   = out_valid_q;
        out_bundle_d  = out_bundle_q;
        skid_valid_d  = skid_valid_q;
        skid_bundle_d = skid_bundle_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            // Output slot is free this edge. An occupied skid entry is older
            // than anything arriving now (and in_ready is low then), so it
            // moves up first.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_bundle_d = skid_bundle_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d  = 1'b1;
                out_bundle_d = res_bundle;
            end else begin
                out_valid_d  = 1'b0;
            end
        end else if (accept) begin
            // Output stalled: park the new bundle in the skid entry.
            skid_valid_d  = 1'b1;
            skid_bundle_d = res_bundle;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid_q  <= 1'b0;
            skid_bundle_q <= srv_defs::OPR_BUNDLE_RESET;
        end else begin
            skid_valid_q  <= skid_valid_d;
            skid_bundle_q <= skid_bundle_d;
        end
    end

`else

    // Ready as soon as the held bundle is leaving this edge, so a stream
    // flows at one instruction per cycle with no bubble.
    assign in_ready = !out_valid_q || out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_bundle_d = out_bundle_q;

        if (flush) begin
            // Flush wins over a same-cycle accept; the accepted one is lost.
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d  = 1'b1;
            out_bundle_d = res_bundle;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_bundle_q <= srv_defs::OPR_BUNDLE_RESET;
        end else begin
            out_valid_q  <= out_valid_d;
            out_bundle_q <= out_bundle_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_s1    = out_bundle_q.s1;
    assign out_s2    = out_bundle_q.s2;
    assign out_opc   = out_bundle_q.opc;
    assign out_rd    = out_bundle_q.rd;

endmodule

// File: tb/tb_opr_stage.sv
// -----------------------------------------------------------------------------
// tb_opr_stage : self-checking bench for opr_stage.
// Inputs change 1 ns after a rising edge; the scoreboard samples on the
// falling edge, where the values seen are exactly those the next rising edge
// will act on.
// -----------------------------------------------------------------------------
module tb_opr_stage;
    import srv_defs::*;

    localparam int XW = 32;
    localparam int RW = 5;
    localparam int BW = 2 * XW + 4 + RW;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [RW-1:0]     in_rs1;
    logic [RW-1:0]     in_rs2;
    logic [RW-1:0]     in_rd;
    logic [XW-1:0]     in_pc;
    logic [XW-1:0]     in_imm;
    logic              in_use_pc;
    logic              in_use_imm;
    alu_opcode_t       in_opc;
    logic [XW-1:0]     rf_rdata1;
    logic [XW-1:0]     rf_rdata2;
    logic [1:0]        byp_valid;
    logic [1:0][RW-1:0] byp_rd;
    logic [1:0][XW-1:0] byp_data;
    logic              out_valid;
    logic              out_ready;
    logic [XW-1:0]     out_s1;
    logic [XW-1:0]     out_s2;
    alu_opcode_t       out_opc;
    logic [RW-1:0]     out_rd;

    int checks;
    int failures;
    logic [BW-1:0] exp_q[$];

    opr_stage #(
        .XLEN      (XW),
        .REG_IDX_W (RW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .in_pc      (in_pc),
        .in_imm     (in_imm),
        .in_use_pc  (in_use_pc),
        .in_use_imm (in_use_imm),
        .in_opc     (in_opc),
        .rf_rdata1  (rf_rdata1),
        .rf_rdata2  (rf_rdata2),
        .byp_valid  (byp_valid),
        .byp_rd     (byp_rd),
        .byp_data   (byp_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_s1     (out_s1),
        .out_s2     (out_s2),
        .out_opc    (out_opc),
        .out_rd     (out_rd)
    );

    // ---------------------------------------------------------------- clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- model
    function automatic logic [XW-1:0] model_src(input logic [RW-1:0] idx,
                                                input logic [XW-1:0] rf);
        if (idx == 0) return '0;
        if (byp_valid[1] && byp_rd[1] == idx) return byp_data[1];
        if (byp_valid[0] && byp_rd[0] == idx) return byp_data[0];
        return rf;
    endfunction

    function automatic logic [BW-1:0] model_bundle();
        logic [XW-1:0] s1;
        logic [XW-1:0] s2;
        s1 = in_use_pc  ? in_pc  : model_src(in_rs1, rf_rdata1);
        s2 = in_use_imm ? in_imm : model_src(in_rs2, rf_rdata2);
        return {s1, s2, in_opc, in_rd};
    endfunction

    // ----------------------------------------------------------- scoreboard
    task automatic sb_sample();
        logic [BW-1:0] got;
        logic [BW-1:0] exp;
        got = {out_s1, out_s2, out_opc, out_rd};
        if (rst || flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: got bundle %h, expected no output", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        failures++;
                        $display("FAIL sb_bundle: got %h, expected %h", got, exp);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model_bundle());
        end
    endtask

    // One cycle: scoreboard at the falling edge, return 1 ns after rising edge.
    task automatic step();
        @(negedge clk);
        sb_sample();
        @(posedge clk);
        #1;
    endtask

    // --------------------------------------------------------------- driver
    task automatic apply(input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                         input logic [RW-1:0] rd, input logic [XW-1:0] pc,
                         input logic [XW-1:0] imm, input logic use_pc,
                         input logic use_imm, input alu_opcode_t opc,
                         input logic [XW-1:0] rf1, input logic [XW-1:0] rf2);
        in_valid   = 1'b1;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_rd      = rd;
        in_pc      = pc;
        in_imm     = imm;
        in_use_pc  = use_pc;
        in_use_imm = use_imm;
        in_opc     = opc;
        rf_rdata1  = rf1;
        rf_rdata2  = rf2;
    endtask

    task automatic apply_random();
        apply(RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
              RW'($urandom_range(0, 31)), $urandom, $urandom,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              alu_opcode_t'($urandom_range(0, 9)), $urandom, $urandom);
        in_valid    = 1'($urandom_range(0, 1));
        byp_valid   = 2'($urandom_range(0, 3));
        byp_rd[0]   = RW'($urandom_range(0, 3));
        byp_rd[1]   = RW'($urandom_range(0, 3));
        byp_data[0] = $urandom;
        byp_data[1] = $urandom;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid: got %b, expected 0", out_valid);
        end
        checks++;
        if ({out_s1, out_s2, out_rd} !== '0) begin
            failures++; $display("FAIL reset_data: got s1=%h s2=%h rd=%0d, expected 0", out_s1, out_s2, out_rd);
        end
        checks++;
        if (out_opc !== ALU_ADD) begin
            failures++; $display("FAIL reset_opc: got %0d, expected %0d", out_opc, ALU_ADD);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        byp_valid = 2'b00;
        apply(5'd3, 5'd4, 5'd1, 32'h100, 32'hFFFF_FFFF, 1'b0, 1'b1, ALU_ADD, 32'h10, 32'h44);
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_s1 !== 32'h10 || out_s2 !== 32'hFFFF_FFFF || out_opc !== ALU_ADD) begin
            failures++;
            $display("FAIL basic: got v=%b s1=%h s2=%h opc=%0d, expected v=1 s1=10 s2=ffffffff opc=0",
                     out_valid, out_s1, out_s2, out_opc);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL basic_drain: got valid %b, expected 0", out_valid);
        end
    endtask

    task automatic test_bypass();
        out_ready   = 1'b1;
        byp_valid   = 2'b11;
        byp_rd[0]   = 5'd5;
        byp_rd[1]   = 5'd5;
        byp_data[0] = 32'hAA;
        byp_data[1] = 32'hBB;
        apply(5'd5, 5'd5, 5'd2, 32'h0, 32'h0, 1'b0, 1'b0, ALU_AND, 32'h11, 32'h11);
        step();
        checks++;
        if (out_s1 !== 32'hBB || out_s2 !== 32'hBB) begin
            failures++; $display("FAIL byp_lane1: got s1=%h s2=%h, expected bb bb", out_s1, out_s2);
        end
        byp_valid = 2'b01;
        step();
        checks++;
        if (out_s1 !== 32'hAA || out_s2 !== 32'hAA) begin
            failures++; $display("FAIL byp_lane0: got s1=%h s2=%h, expected aa aa", out_s1, out_s2);
        end
        byp_rd[0]   = 5'd0;
        byp_data[0] = 32'h55;
        apply(5'd0, 5'd6, 5'd3, 32'h0, 32'h0, 1'b0, 1'b0, ALU_OR, 32'h77, 32'h66);
        step();
        checks++;
        if (out_s1 !== 32'h0 || out_s2 !== 32'h66) begin
            failures++; $display("FAIL byp_zero: got s1=%h s2=%h, expected 0 66", out_s1, out_s2);
        end
        byp_valid = 2'b11;
        byp_rd[0] = 5'd7;
        byp_rd[1] = 5'd6;
        apply(5'd7, 5'd6, 5'd4, 32'h1000, 32'h0, 1'b1, 1'b0, ALU_SLT, 32'h1, 32'h2);
        step();
        in_valid = 1'b0;
        checks++;
        if (out_s1 !== 32'h1000 || out_s2 !== 32'hBB) begin
            failures++; $display("FAIL byp_use_pc: got s1=%h s2=%h, expected 1000 bb", out_s1, out_s2);
        end
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            apply_random();
            in_valid = 1'b1;
            step();
            checks++;
            if (out_valid !== 1'b1) begin
                failures++; $display("FAIL b2b_valid[%0d]: got %b, expected 1", i, out_valid);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_random_backpressure();
        logic exp_ready;
        for (int i = 0; i < 80; i++) begin
            apply_random();
            out_ready = 1'b1;
            if ($urandom_range(0, 2) == 0) out_ready = 1'b0;
            #0;
`ifdef SRV_OPR_SKID_EN
            exp_ready = (exp_q.size() < 2);
`else
            exp_ready = (exp_q.size() == 0) || out_ready;
`endif
            checks++;
            if (in_ready !== exp_ready) begin
                failures++; $display("FAIL rand_in_ready[%0d]: got %b, expected %b", i, in_ready, exp_ready);
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && (exp_q.size() != 0 || out_valid); i++) step();
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL rand_drain: got %0d pending, valid %b, expected 0 0", exp_q.size(), out_valid);
        end
    endtask

    task automatic test_stall();
        logic exp_ready;
        out_ready = 1'b0;
        byp_valid = 2'b00;
        apply(5'd7, 5'd8, 5'd9, 32'h0, 32'h20, 1'b0, 1'b1, ALU_SUB, 32'h1234, 32'h5);
        step();
        apply(5'd7, 5'd7, 5'd10, 32'h2000, 32'h30, 1'b1, 1'b1, ALU_XOR, 32'h1, 32'h2);
        for (int i = 0; i < 3; i++) begin
            byp_valid   = 2'b11;
            byp_rd[0]   = 5'd7;
            byp_rd[1]   = 5'd7;
            byp_data[0] = $urandom;
            byp_data[1] = $urandom;
            #0;
`ifdef SRV_OPR_SKID_EN
            exp_ready = (i == 0);
`else
            exp_ready = 1'b0;
`endif
            checks++;
            if (in_ready !== exp_ready) begin
                failures++; $display("FAIL stall_ready[%0d]: got %b, expected %b", i, in_ready, exp_ready);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_s1 !== 32'h1234 || out_s2 !== 32'h20 ||
                out_opc !== ALU_SUB || out_rd !== 5'd9) begin
                failures++;
                $display("FAIL stall_hold[%0d]: got v=%b s1=%h s2=%h opc=%0d rd=%0d, expected 1 1234 20 1 9",
                         i, out_valid, out_s1, out_s2, out_opc, out_rd);
            end
        end
        out_ready = 1'b1;
`ifdef SRV_OPR_SKID_EN
        in_valid = 1'b0;
`endif
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_s1 !== 32'h2000 || out_s2 !== 32'h30 || out_opc !== ALU_XOR) begin
            failures++;
            $display("FAIL stall_second: got v=%b s1=%h s2=%h opc=%0d, expected 1 2000 30 4",
                     out_valid, out_s1, out_s2, out_opc);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL stall_drain: got valid %b, expected 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        byp_valid = 2'b00;
        apply(5'd1, 5'd2, 5'd11, 32'h0, 32'h0, 1'b0, 1'b0, ALU_SRL, 32'hA1, 32'hA2);
        step();
        apply(5'd3, 5'd4, 5'd12, 32'h0, 32'h0, 1'b0, 1'b0, ALU_SRA, 32'hB1, 32'hB2);
        flush = 1'b1;
`ifndef SRV_OPR_SKID_EN
        out_ready = 1'b1;
`endif
        #0;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL flush_in_ready: got %b, expected 1", in_ready);
        end
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL flush_valid: got %b, expected 0", out_valid);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++; $display("FAIL flush_after[%0d]: got valid %b, expected 0", i, out_valid);
            end
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        byp_valid = 2'b00;
        apply(5'd4, 5'd5, 5'd13, 32'h0, 32'h0, 1'b0, 1'b0, ALU_SLL, 32'hDEAD, 32'hBEEF);
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_s1 !== 32'hDEAD) begin
            failures++; $display("FAIL arst_pre: got v=%b s1=%h, expected 1 dead", out_valid, out_s1);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_s1 !== 32'h0 || out_opc !== ALU_ADD || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL arst_mid: got v=%b s1=%h opc=%0d rdy=%b, expected 0 0 0 1",
                     out_valid, out_s1, out_opc, in_ready);
        end
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        apply(5'd2, 5'd0, 5'd14, 32'h0, 32'h0, 1'b0, 1'b0, ALU_OR, 32'h99, 32'h1);
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_s1 !== 32'h99 || out_s2 !== 32'h0 || out_opc !== ALU_OR) begin
            failures++;
            $display("FAIL arst_resume: got v=%b s1=%h s2=%h opc=%0d, expected 1 99 0 3",
                     out_valid, out_s1, out_s2, out_opc);
        end
        step();
    endtask

    // ----------------------------------------------------------------- main
    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b0;
        flush       = 1'b0;
        out_ready   = 1'b1;
        byp_valid   = 2'b00;
        byp_rd[0]   = '0;
        byp_rd[1]   = '0;
        byp_data[0] = '0;
        byp_data[1] = '0;
        apply('0, '0, '0, '0, '0, 1'b0, 1'b0, ALU_ADD, '0, '0);
        in_valid    = 1'b0;
        #1;

        test_reset();
        test_basic();
        test_bypass();
        test_back_to_back();
        test_stall();
        test_flush();
        test_random_backpressure();
        test_async_reset();

        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL final_queue: got %0d pending bundles, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
